// File: rtl/mux_alu_b_if.sv
// Operand-B select bus: operand sources, forwarding control, pipeline
// control and the combinational/registered operand outputs.
interface mux_alu_b_if;
    logic [31:0] immgen;
    logic [31:0] ru_rs2;
    logic        aluBSrc;
    logic [1:0]  fwd_sel;
    logic [31:0] exmem_result;
    logic [31:0] memwb_result;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] aluB;
    logic [4:0]  shamt;
    logic [31:0] aluB_q;
    logic        out_valid;

    // Decode/forwarding side: drives sources and control, observes the operand.
    modport master (
        output immgen, ru_rs2, aluBSrc, fwd_sel, exmem_result, memwb_result,
               in_valid, stall, flush,
        input  aluB, shamt, aluB_q, out_valid
    );

    // Select stage itself.
    modport slave (
        input  immgen, ru_rs2, aluBSrc, fwd_sel, exmem_result, memwb_result,
               in_valid, stall, flush,
        output aluB, shamt, aluB_q, out_valid
    );
endinterface

// File: rtl/mux_alu_b.sv
// ALU operand-B select stage for the RV32I core. Picks the second ALU operand
// from rs2, the immediate or one of two forwarded results, drives it straight
// to the ALU and also captures it in a stall/flush-controlled pipeline register.
module mux_alu_b (
    input  logic         clk,
    input  logic         rst,
    mux_alu_b_if.slave   bus
);

    logic [31:0] reg_b_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_b_d;
    logic [31:0] alu_b_q;
    logic        valid_d;
    logic        valid_q;

    // Register-path forwarding mux; encoding 11 deliberately aliases 00.
    always_comb begin
        reg_b_s = bus.ru_rs2;
        case (bus.fwd_sel)
            2'b01:   reg_b_s = bus.exmem_result;
            2'b10:   reg_b_s = bus.memwb_result;
            default: reg_b_s = bus.ru_rs2;
        endcase
    end

    // Immediate overrides the register path regardless of forwarding.
    always_comb begin
        alu_b_s = reg_b_s;
        if (bus.aluBSrc == 1'b1) begin
            alu_b_s = bus.immgen;
        end else begin
            alu_b_s = reg_b_s;
        end
    end

    // Pipeline next state: flush beats stall; a bubble still loads the operand.
    always_comb begin
        alu_b_d = alu_b_q;
        valid_d = valid_q;
        if (bus.flush == 1'b1) begin
            alu_b_d = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (bus.stall == 1'b1) begin
            alu_b_d = alu_b_q;
            valid_d = valid_q;
        end else begin
            alu_b_d = alu_b_s;
            valid_d = bus.in_valid;
        end
    end

    // Pipeline register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_b_q <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            alu_b_q <= alu_b_d;
            valid_q <= valid_d;
        end
    end

    assign bus.aluB      = alu_b_s;
    assign bus.shamt     = alu_b_s[4:0];
    assign bus.aluB_q    = alu_b_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_alu_b.sv
// Directed testbench for mux_alu_b: operand selection, forwarding, and the
// stall/flush/reset behaviour of the pipeline register.
module tb_mux_alu_b;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mux_alu_b_if bus_if ();

    mux_alu_b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.aluBSrc = 1'b0; bus_if.fwd_sel = 2'b00;
        bus_if.ru_rs2 = 32'hCAFE_0013; bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'h0) begin
            n_errors++; $display("FAIL reset_aluB_q actual=%h required=%h", bus_if.aluB_q, 32'h0);
        end
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid actual=%b required=%b", bus_if.out_valid, 1'b0);
        end
        n_checks++;
        if (bus_if.aluB !== 32'hCAFE_0013 || bus_if.shamt !== 5'd19) begin
            n_errors++; $display("FAIL reset_comb_follow actual=%h/%0d required=%h/%0d", bus_if.aluB, bus_if.shamt, 32'hCAFE_0013, 19);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_select();
        @(negedge clk);
        bus_if.immgen = 32'h0000_0001; bus_if.ru_rs2 = 32'h0000_0002;
        bus_if.aluBSrc = 1'b0; bus_if.fwd_sel = 2'b00;
        #1;
        n_checks++;
        if (bus_if.aluB !== 32'h0000_0002) begin
            n_errors++; $display("FAIL reg_select actual=%h required=%h", bus_if.aluB, 32'h2);
        end
        bus_if.immgen = 32'h0000_0003; bus_if.ru_rs2 = 32'h0000_0004;
        bus_if.aluBSrc = 1'b1; bus_if.fwd_sel = 2'b01;
        #1;
        n_checks++;
        if (bus_if.aluB !== 32'h0000_0003 || bus_if.shamt !== 5'd3) begin
            n_errors++; $display("FAIL imm_select actual=%h/%0d required=%h/%0d", bus_if.aluB, bus_if.shamt, 32'h3, 3);
        end
    endtask

    task automatic test_forwarding();
        logic [1:0]  sel_v [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] exp_v [4]  = '{32'h1111_1111, 32'hAAAA_0005, 32'h5555_001F, 32'h1111_1111};
        logic [4:0]  exp_sh [4] = '{5'd17, 5'd5, 5'd31, 5'd17};
        @(negedge clk);
        bus_if.aluBSrc = 1'b0; bus_if.immgen = 32'h0000_0000;
        bus_if.ru_rs2 = 32'h1111_1111;
        bus_if.exmem_result = 32'hAAAA_0005; bus_if.memwb_result = 32'h5555_001F;
        for (int i = 0; i < 4; i++) begin
            bus_if.fwd_sel = sel_v[i];
            #1;
            n_checks++;
            if (bus_if.aluB !== exp_v[i] || bus_if.shamt !== exp_sh[i]) begin
                n_errors++; $display("FAIL fwd_sel_%b actual=%h/%0d required=%h/%0d", sel_v[i], bus_if.aluB, bus_if.shamt, exp_v[i], exp_sh[i]);
            end
        end
    endtask

    task automatic test_register_load();
        @(negedge clk);
        bus_if.aluBSrc = 1'b0; bus_if.fwd_sel = 2'b00;
        bus_if.ru_rs2 = 32'hDEAD_BEEF; bus_if.in_valid = 1'b1;
        bus_if.stall = 1'b0; bus_if.flush = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'hDEAD_BEEF || bus_if.out_valid !== 1'b1) begin
            n_errors++; $display("FAIL reg_load actual=%h/%b required=%h/%b", bus_if.aluB_q, bus_if.out_valid, 32'hDEAD_BEEF, 1'b1);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus_if.stall = 1'b1; bus_if.ru_rs2 = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus_if.aluB_q !== 32'hDEAD_BEEF || bus_if.out_valid !== 1'b1 || bus_if.aluB !== 32'h1234_5678) begin
                n_errors++; $display("FAIL stall_hold_%0d actual=%h/%b/%h required=%h/%b/%h", i, bus_if.aluB_q, bus_if.out_valid, bus_if.aluB, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
            end
        end
        @(negedge clk);
        bus_if.stall = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'h1234_5678) begin
            n_errors++; $display("FAIL stall_release actual=%h required=%h", bus_if.aluB_q, 32'h1234_5678);
        end
    endtask

    task automatic test_flush_priority();
        @(negedge clk);
        bus_if.stall = 1'b1; bus_if.flush = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'h0 || bus_if.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_over_stall actual=%h/%b required=%h/%b", bus_if.aluB_q, bus_if.out_valid, 32'h0, 1'b0);
        end
        @(negedge clk);
        bus_if.stall = 1'b0; bus_if.flush = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.ru_rs2 = 32'h0000_000F;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'h0000_000F || bus_if.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bubble_load actual=%h/%b required=%h/%b", bus_if.aluB_q, bus_if.out_valid, 32'hF, 1'b0);
        end
    endtask

    task automatic test_imm_load_and_reset_in_stall();
        @(negedge clk);
        bus_if.aluBSrc = 1'b1; bus_if.fwd_sel = 2'b10;
        bus_if.immgen = 32'h8000_0FF0; bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'h8000_0FF0 || bus_if.out_valid !== 1'b1) begin
            n_errors++; $display("FAIL imm_load actual=%h/%b required=%h/%b", bus_if.aluB_q, bus_if.out_valid, 32'h8000_0FF0, 1'b1);
        end
        @(negedge clk);
        bus_if.stall = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.aluB_q !== 32'h0 || bus_if.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_in_stall actual=%h/%b required=%h/%b", bus_if.aluB_q, bus_if.out_valid, 32'h0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0; bus_if.stall = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.immgen = 32'h0; bus_if.ru_rs2 = 32'h0; bus_if.aluBSrc = 1'b0;
        bus_if.fwd_sel = 2'b00; bus_if.exmem_result = 32'h0; bus_if.memwb_result = 32'h0;
        bus_if.in_valid = 1'b0; bus_if.stall = 1'b0; bus_if.flush = 1'b0;
        test_reset();
        test_select();
        test_forwarding();
        test_register_load();
        test_stall();
        test_flush_priority();
        test_imm_load_and_reset_in_stall();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
